out_display_driver: RTL and testbench

- Downstream consumer of the SAP-1 output register.
- Captures the 8-bit output-register value whenever the controller pulses Lo.
- Converts the value to decimal with a sequential double-dabble engine, in unsigned or signed mode.
- Drives a 4-digit multiplexed 7-segment display: digit 3 is the sign, digits 2..0 are hundreds, tens and ones.

---
 rtl/out_display_driver.sv | 159 +++++++++++++++
 tb/tb_out_display_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/out_display_driver.sv
// rtl/out_display_driver.sv - SAP-1 output register capture, double-dabble decimal conversion, 4-digit scan
module out_display_driver #(
  parameter int SCAN_DIV   = 16,
  parameter int BLANK_LZ   = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        out_load,
  input  logic [7:0]  out_data,
  input  logic        signed_mode,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd,
  output logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state;
  logic          load_q;
  logic          pending;
  logic [7:0]    hold_data;
  logic          hold_sm;
  logic [7:0]    mag;
  logic [11:0]   bcd_t;
  logic          sign_t;
  logic [2:0]    cnt;
  logic [PW-1:0] presc;
  logic [1:0]    dig;

  logic [7:0]  st_data;
  logic        st_sm;
  logic [11:0] adj;
  logic [6:0]  raw_seg;
  logic [3:0]  raw_an;

  function automatic logic [3:0] dd_nib(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // A fresh load on the DONE edge is newer than anything held, so it wins.
  always_comb begin
    st_data = out_data;
    st_sm   = signed_mode;
    if (state == DONE && !load_q && pending) begin
      st_data = hold_data;
      st_sm   = hold_sm;
    end
  end

  assign adj  = {dd_nib(bcd_t[11:8]), dd_nib(bcd_t[7:4]), dd_nib(bcd_t[3:0])};
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (CLR) begin
      state     <= IDLE;
      load_q    <= 1'b0;
      pending   <= 1'b0;
      hold_data <= 8'd0;
      hold_sm   <= 1'b0;
      mag       <= 8'd0;
      bcd_t     <= 12'd0;
      sign_t    <= 1'b0;
      cnt       <= 3'd0;
      valid     <= 1'b0;
      bcd       <= 12'd0;
      neg       <= 1'b0;
      presc     <= '0;
      dig       <= 2'd0;
    end else begin
      load_q <= out_load;

      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        dig   <= dig + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: begin
          if (load_q) begin
            mag    <= (st_sm && st_data[7]) ? (~st_data + 8'd1) : st_data;
            sign_t <= st_sm & st_data[7];
            bcd_t  <= 12'd0;
            cnt    <= 3'd0;
            state  <= CONV;
          end
        end
        CONV: begin
          {bcd_t, mag} <= {adj[10:0], mag, 1'b0};
          cnt          <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
          if (load_q) begin
            pending   <= 1'b1;
            hold_data <= out_data;
            hold_sm   <= signed_mode;
          end
        end
        DONE: begin
          bcd   <= bcd_t;
          neg   <= sign_t;
          valid <= 1'b1;
          if (load_q || pending) begin
            pending <= 1'b0;
            mag     <= (st_sm && st_data[7]) ? (~st_data + 8'd1) : st_data;
            sign_t  <= st_sm & st_data[7];
            bcd_t   <= 12'd0;
            cnt     <= 3'd0;
            state   <= CONV;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    raw_an  = 4'b0001 << dig;
    raw_seg = 7'h00;
    case (dig)
      2'd3: raw_seg = neg ? 7'h40 : 7'h00;
      2'd2: raw_seg = (BLANK_LZ != 0 && bcd[11:8] == 4'd0) ? 7'h00 : seg7(bcd[11:8]);
      2'd1: raw_seg = (BLANK_LZ != 0 && bcd[11:4] == 8'd0) ? 7'h00 : seg7(bcd[7:4]);
      default: raw_seg = seg7(bcd[3:0]);
    endcase
    if (!valid) begin
      raw_an  = 4'b0000;
      raw_seg = 7'h00;
    end
  end

  assign seg = (ACTIVE_LOW != 0) ? ~raw_seg : raw_seg;
  assign an  = (ACTIVE_LOW != 0) ? ~raw_an  : raw_an;

endmodule

// File: tb/tb_out_display_driver.sv
// tb/tb_out_display_driver.sv - scoreboard bench for out_display_driver
module tb_out_display_driver;

  logic        clk = 1'b0;
  logic        CLR;
  logic        out_load;
  logic [7:0]  out_data;
  logic        signed_mode;
  logic        busy;
  logic        valid;
  logic [11:0] bcd;
  logic        neg;
  logic [6:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  out_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut (
    .clk(clk), .CLR(CLR), .out_load(out_load), .out_data(out_data),
    .signed_mode(signed_mode), .busy(busy), .valid(valid), .bcd(bcd),
    .neg(neg), .seg(seg), .an(an)
  );

  typedef struct {
    int          due;
    logic [11:0] b;
    logic        n;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Display updates are compared on the cycle each conversion is due to land.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("disp_bcd",   32'(bcd),   32'(e.b));
      chk("disp_neg",   32'(neg),   32'(e.n));
      chk("disp_valid", 32'(valid), 32'd1);
    end
  end

  task automatic issue(input logic [7:0] d, input logic sm, input logic [11:0] eb,
                       input logic en, input bit push, input int off);
    exp_t e;
    out_load    = 1'b1;
    out_data    = d;
    signed_mode = sm;
    if (push) begin
      e.due = cyc + off;
      e.b   = eb;
      e.n   = en;
      q.push_back(e);
    end
    @(negedge clk);
    out_load = 1'b0;
  endtask

  task automatic check_scan(input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0);
    logic [3:0] ea [4];
    logic [6:0] es [4];
    int t;
    ea[0] = 4'b1110; ea[1] = 4'b1101; ea[2] = 4'b1011; ea[3] = 4'b0111;
    es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
    t = 0;
    while (an !== 4'b0111 && t < 100) begin @(negedge clk); t++; end
    while (an !== 4'b1110 && t < 100) begin @(negedge clk); t++; end
    chk("scan_sync_timeout", 32'(t >= 100), 32'd0);
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 4; j++) begin
        chk("scan_an",  32'(an),  32'(ea[s]));
        chk("scan_seg", 32'(seg), 32'(es[s]));
        @(negedge clk);
      end
    end
    chk("scan_wrap_an", 32'(an), 32'(4'b1110));
  endtask

  initial begin
    CLR = 1'b1; out_load = 1'b0; out_data = 8'h00; signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd",   32'(bcd),   32'd0);
    chk("rst_neg",   32'(neg),   32'd0);
    chk("rst_seg",   32'(seg),   32'h7F);
    chk("rst_an",    32'(an),    32'hF);
    CLR = 1'b0;
    @(negedge clk);

    // 0x01 unsigned, with busy timing around the capture edge
    issue(8'h01, 1'b0, 12'h001, 1'b0, 1'b1, 11);
    chk("busy_k", 32'(busy), 32'd0);
    @(negedge clk);
    chk("busy_k1", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    check_scan(7'h7F, 7'h7F, 7'h7F, 7'h79);

    issue(8'hFF, 1'b0, 12'h255, 1'b0, 1'b1, 11);
    repeat (12) @(negedge clk);
    check_scan(7'h7F, 7'h24, 7'h12, 7'h12);

    issue(8'hFF, 1'b1, 12'h001, 1'b1, 1'b1, 11);
    repeat (12) @(negedge clk);
    check_scan(7'h3F, 7'h7F, 7'h7F, 7'h79);

    issue(8'h80, 1'b1, 12'h128, 1'b1, 1'b1, 11);
    repeat (12) @(negedge clk);
    check_scan(7'h3F, 7'h79, 7'h24, 7'h00);

    // second load arrives mid-conversion and is held until the first lands
    issue(8'h0A, 1'b0, 12'h010, 1'b0, 1'b1, 11);
    @(negedge clk);
    chk("pend_busy_a", 32'(busy), 32'd1);
    @(negedge clk);
    chk("pend_busy_b", 32'(busy), 32'd1);
    issue(8'h64, 1'b0, 12'h100, 1'b0, 1'b1, 17);
    for (int i = 0; i < 16; i++) begin
      chk("pend_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("pend_idle", 32'(busy), 32'd0);
    check_scan(7'h7F, 7'h79, 7'h40, 7'h40);

    // reset during a conversion, then a normal conversion
    issue(8'h55, 1'b0, 12'h000, 1'b0, 1'b0, 0);
    @(negedge clk);
    CLR = 1'b1;
    @(negedge clk);
    chk("clr_busy",  32'(busy),  32'd0);
    chk("clr_valid", 32'(valid), 32'd0);
    chk("clr_seg",   32'(seg),   32'h7F);
    chk("clr_an",    32'(an),    32'hF);
    chk("clr_bcd",   32'(bcd),   32'd0);
    CLR = 1'b0;
    @(negedge clk);
    issue(8'h7F, 1'b1, 12'h127, 1'b0, 1'b1, 11);
    repeat (12) @(negedge clk);
    check_scan(7'h7F, 7'h79, 7'h24, 7'h78);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
